// File: rtl/control_fetch_stage.sv
// control_fetch_stage
//   Instruction fetch stage feeding the main decoder. Owns the PC, drives a
//   synchronous instruction memory, and presents the returned word together
//   with its PC and the decoder fields op/funct5/funct0. Supports a
//   decode-side stall, an execute-side branch redirect with a one-slot flush,
//   and counts instructions accepted by the decoder.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   imem_addr/en    fetch address (= pc_q) and read enable to the memory
//   imem_rdata      word returned for the address issued on the last enabled edge
//   stall           decoder cannot take the current instruction
//   branch_taken    redirect request from execute, with branch_target
//   instr, instr_valid, instr_pc, instr_pc_next
//                   instruction to decode, its qualifier, its PC and PC + PC_STEP
//   op, funct5, funct0
//                   decoder fields sliced from instr
//   fetch_cnt       wrapping count of accepted instructions
module control_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_next,
    output logic [1:0]         op,
    output logic               funct5,
    output logic               funct0,
    output logic [CNT_W-1:0]   fetch_cnt
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    // BOOT: first fetch in flight; RUN: memory output is a real instruction;
    // FLUSH: memory output belongs to the wrong path and is dropped.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic              hold;
    logic              accept;

    // A redirect always lands in FLUSH because the word already requested
    // from memory is the one after the branch; otherwise the next word is good.
    // A stall only freezes the pipe while a real instruction is presented,
    // and a redirect overrides it so the pipe never sits on a dead word.
    always_comb begin
        state_d     = RUN;
        hold        = 1'b0;
        instr_valid = 1'b0;
        accept      = 1'b0;
        if (branch_taken) begin
            state_d = FLUSH;
        end
        hold        = (state_q == RUN) && stall && !branch_taken;
        instr_valid = (state_q == RUN) && !branch_taken;
        accept      = instr_valid && !stall;
    end

    // State, PC, PC-of-instruction and accept counter. instr_pc tracks the
    // address the memory is currently returning, so it only moves on edges
    // where the memory actually performs a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_pc  <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (!hold) begin
                instr_pc <= pc_q;
            end
            if (branch_taken) begin
                pc_q <= branch_target;
            end else if (!hold) begin
                pc_q <= pc_q + STEP;
            end
            if (accept) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    // The memory holds its output while disabled, so a stalled instruction
    // stays stable without a local copy.
    assign imem_addr     = pc_q;
    assign imem_en       = !hold;
    assign instr         = imem_rdata;
    assign instr_pc_next = instr_pc + STEP;
    assign op            = instr[27:26];
    assign funct5        = instr[25];
    assign funct0        = instr[20];

endmodule

// File: tb/tb_control_fetch_stage.sv
// tb_control_fetch_stage
//   Directed bench for control_fetch_stage with a behavioural synchronous
//   instruction memory. Expected PCs of accepted instructions are queued as
//   the stimulus is driven and popped whenever the decoder accepts a word.
module tb_control_fetch_stage;

    localparam int ADDR_W = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [ADDR_W-1:0]  instr_pc;
    logic [ADDR_W-1:0]  instr_pc_next;
    logic [1:0]         op;
    logic               funct5;
    logic               funct0;
    logic [CNT_W-1:0]   fetch_cnt;

    int                 testCnt;
    int                 failCnt;
    int                 modelCnt;
    logic [ADDR_W-1:0]  sbq[$];

    control_fetch_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RESET_PC('0),
        .PC_STEP (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_pc     (instr_pc),
        .instr_pc_next(instr_pc_next),
        .op           (op),
        .funct5       (funct5),
        .funct0       (funct0),
        .fetch_cnt    (fetch_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents as a pure function of the address; address 0x8 holds a
    // word with known decoder fields.
    function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        if (a == 32'h0000_0008) begin
            return 32'h0A10_0000;
        end
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Synchronous read memory that holds its output when disabled.
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= memWord(imem_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic bt, input logic [ADDR_W-1:0] tgt);
        stall         = st;
        branch_taken  = bt;
        branch_target = tgt;
        #1;
    endtask

    // One clock edge. When the bench expects the decoder to accept the word on
    // this edge, the oldest queued PC is popped and compared.
    task automatic advance(input logic expAccept);
        logic [ADDR_W-1:0] expPc;
        checkOutput("accept", {31'd0, instr_valid & ~stall}, {31'd0, expAccept});
        if (expAccept) begin
            modelCnt++;
            if (sbq.size() == 0) begin
                checkOutput("sb_underflow", 32'd0, 32'd1);
            end else begin
                expPc = sbq.pop_front();
                checkOutput("sb_pc", instr_pc, expPc);
                checkOutput("sb_instr", instr, memWord(expPc));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkCnt(input string tag);
        checkOutput(tag, {28'd0, fetch_cnt}, 32'(modelCnt % 16));
    endtask

    initial begin
        testCnt  = 0;
        failCnt  = 0;
        modelCnt = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);

        // Reset state.
        @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_pc", instr_pc, 32'h0);
        checkOutput("rst_en", {31'd0, imem_en}, 32'd1);
        checkCnt("rst_cnt");

        // First fetch after release, then sequential stream.
        rst_n = 1'b1;
        #1;
        advance(1'b0);
        checkOutput("boot_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("boot_pc_next", instr_pc_next, 32'h4);
        checkOutput("boot_addr", imem_addr, 32'h4);
        sbq.push_back(32'h0);
        advance(1'b1);
        checkCnt("cnt_after_i0");

        // Stall for three cycles while I1 is presented.
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("stall_en", {31'd0, imem_en}, 32'd0);
        checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            advance(1'b0);
            checkOutput("stall_pc", instr_pc, 32'h4);
            checkOutput("stall_instr", instr, memWord(32'h4));
            checkOutput("stall_addr", imem_addr, 32'h8);
            checkCnt("stall_cnt");
        end
        applyStimulus(1'b0, 1'b0, '0);
        sbq.push_back(32'h4);
        advance(1'b1);
        checkOutput("i2_pc", instr_pc, 32'h8);
        checkOutput("op", {30'd0, op}, 32'd2);
        checkOutput("funct5", {31'd0, funct5}, 32'd1);
        checkOutput("funct0", {31'd0, funct0}, 32'd1);
        checkCnt("cnt_after_i1");

        // Branch to 0x40 while I2 is presented: two dead cycles.
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkOutput("br_kill", {31'd0, instr_valid}, 32'd0);
        checkOutput("br_en", {31'd0, imem_en}, 32'd1);
        advance(1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("flush_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("flush_addr", imem_addr, 32'h40);
        advance(1'b0);
        checkOutput("tgt_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("tgt_pc", instr_pc, 32'h40);
        checkOutput("tgt_instr", instr, memWord(32'h40));
        checkCnt("cnt_after_br");

        // Branch and stall together: redirect wins, no hold.
        applyStimulus(1'b1, 1'b1, 32'hC0);
        checkOutput("brst_en", {31'd0, imem_en}, 32'd1);
        checkOutput("brst_valid", {31'd0, instr_valid}, 32'd0);
        advance(1'b0);
        checkOutput("brst_addr", imem_addr, 32'hC0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("flush_stall_valid", {31'd0, instr_valid}, 32'd0);
        advance(1'b0);
        checkOutput("brst_pc", instr_pc, 32'hC0);
        checkOutput("brst_instr", instr, memWord(32'hC0));
        checkOutput("brst_hold_en", {31'd0, imem_en}, 32'd0);
        checkOutput("brst_hold_addr", imem_addr, 32'hC4);

        // Back-to-back branches: first valid word comes from the second target.
        applyStimulus(1'b0, 1'b1, 32'h40);
        advance(1'b0);
        applyStimulus(1'b0, 1'b1, 32'h80);
        advance(1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("b2b_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("b2b_addr", imem_addr, 32'h80);
        advance(1'b0);
        sbq.push_back(32'h80);
        advance(1'b1);
        checkOutput("b2b_next_pc", instr_pc, 32'h84);
        checkCnt("cnt_after_b2b");

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("mid_rst_addr", imem_addr, 32'h0);
        checkOutput("mid_rst_pc", instr_pc, 32'h0);
        modelCnt = 0;
        checkCnt("mid_rst_cnt");
        advance(1'b0);
        rst_n = 1'b1;
        #1;
        advance(1'b0);
        checkOutput("re_boot_pc", instr_pc, 32'h0);

        // Seventeen accepts wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            sbq.push_back(32'(i * 4));
            advance(1'b1);
            if (i == 15) begin
                checkCnt("cnt_wrap0");
            end
        end
        checkCnt("cnt_wrap1");

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        advance(1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        advance(1'b0);
        checkOutput("top_pc", instr_pc, 32'hFFFF_FFFC);
        checkOutput("top_pc_next", instr_pc_next, 32'h0);
        checkOutput("top_addr", imem_addr, 32'h0);
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
